// File: rtl/hd44780_text_loader.sv
// Buffers appended HD44780 command/data bytes into instruction RAM, then on commit
// terminates the list with STOP and hands it to the LCD controller, waiting for it to finish.
module hd44780_text_loader #(
    parameter int ram_awidth = 8,
    parameter int ram_dwidth = 16,
    parameter int base_addr  = 0,
    parameter int max_len    = 32
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  STB_I,
    input  logic                  CMT_I,
    input  logic [8:0]            DAT_I,
    output logic                  ACK_O,
    output logic [ram_awidth-1:0] o_waddr,
    output logic [ram_dwidth-1:0] o_wdata,
    output logic                  o_wen,
    output logic                  o_ctrl_stb,
    output logic [ram_awidth-1:0] o_start_addr,
    input  logic                  i_ctrl_busy,
    input  logic                  i_ctrl_error,
    output logic                  busy,
    output logic                  error,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(max_len + 1);
    localparam logic [ram_dwidth-1:0] STOP_WORD = {2'b11, {(ram_dwidth-2){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_STOPW,
        S_STROBE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_count;
    logic [3:0]            r_tmo;
    logic                  r_ack;
    logic                  r_wen;
    logic [ram_awidth-1:0] r_waddr;
    logic [ram_dwidth-1:0] r_wdata;
    logic                  r_error;
    logic                  r_overflow;

    logic                  w_req;
    logic                  w_app;
    logic                  w_cmt;
    logic                  w_full;
    logic                  w_tmo;
    logic                  w_done;
    logic [ram_awidth-1:0] w_addr;

    // The ACK_O cycle never accepts a request, so a held STB_I yields one request per two cycles.
    assign w_req  = (r_state == S_IDLE) && STB_I && !r_ack;
    assign w_app  = w_req && !CMT_I;
    assign w_cmt  = w_req && CMT_I;
    assign w_full = (r_count == CNT_W'(max_len));
    assign w_tmo  = (r_tmo == 4'd15);
    assign w_addr = ram_awidth'(base_addr) + ram_awidth'(r_count);

    assign ACK_O        = r_ack;
    assign o_wen        = r_wen;
    assign o_waddr      = r_waddr;
    assign o_wdata      = r_wdata;
    assign o_start_addr = ram_awidth'(base_addr);
    assign error        = r_error;
    assign overflow     = r_overflow;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_cmt && (r_count != '0)) w_next = S_STOPW;
            S_STOPW:   w_next = S_STROBE;
            S_STROBE:  w_next = S_WAIT_HI;
            S_WAIT_HI: if (i_ctrl_busy || w_tmo) w_next = S_WAIT_LO;
            S_WAIT_LO: if (!i_ctrl_busy) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        o_ctrl_stb = (r_state == S_STROBE);
        w_done     = (r_state == S_WAIT_LO) && !i_ctrl_busy;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_count    <= '0;
            r_tmo      <= '0;
            r_ack      <= 1'b0;
            r_wen      <= 1'b0;
            r_waddr    <= ram_awidth'(base_addr);
            r_wdata    <= '0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_wen <= 1'b0;
            if (w_app) begin
                r_ack <= 1'b1;
                if (!w_full) begin
                    r_wen   <= 1'b1;
                    r_waddr <= w_addr;
                    r_wdata <= ram_dwidth'(DAT_I);
                    r_count <= r_count + CNT_W'(1);
                end else begin
                    r_overflow <= 1'b1;
                end
            end
            // Flags clear at commit entry; the STOP write happens in the STOPW cycle.
            if (w_cmt) begin
                r_error    <= 1'b0;
                r_overflow <= 1'b0;
                if (r_count == '0) begin
                    r_ack <= 1'b1;
                end else begin
                    r_wen   <= 1'b1;
                    r_waddr <= w_addr;
                    r_wdata <= STOP_WORD;
                end
            end
            if (r_state == S_STROBE) begin
                r_tmo <= '0;
            end else if (r_state == S_WAIT_HI) begin
                r_tmo <= r_tmo + 4'd1;
            end
            if ((r_state == S_WAIT_HI) && !i_ctrl_busy && w_tmo) begin
                r_error <= 1'b1;
            end
            if (w_done) begin
                r_error <= r_error | i_ctrl_error;
                r_count <= '0;
                r_ack   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hd44780_text_loader.sv
// Directed bench for hd44780_text_loader with a small LCD-controller busy model.
module tb_hd44780_text_loader;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       STB_I = 1'b0;
    logic       CMT_I = 1'b0;
    logic [8:0] DAT_I = '0;
    logic       ACK_O;
    logic [7:0] o_waddr;
    logic [15:0] o_wdata;
    logic       o_wen;
    logic       o_ctrl_stb;
    logic [7:0] o_start_addr;
    logic       i_ctrl_busy = 1'b0;
    logic       i_ctrl_error = 1'b0;
    logic       busy;
    logic       error;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    int ctl_delay = 3;
    int ctl_len   = 20;
    bit ctl_never = 1'b0;
    int m_cnt     = 0;
    bit m_act     = 1'b0;

    hd44780_text_loader #(
        .ram_awidth(8), .ram_dwidth(16), .base_addr(0), .max_len(32)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .CMT_I(CMT_I), .DAT_I(DAT_I),
        .ACK_O(ACK_O), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
        .o_ctrl_stb(o_ctrl_stb), .o_start_addr(o_start_addr),
        .i_ctrl_busy(i_ctrl_busy), .i_ctrl_error(i_ctrl_error),
        .busy(busy), .error(error), .overflow(overflow)
    );

    always #5 CLK_I = ~CLK_I;

    // Controller model: busy rises ctl_delay cycles after the strobe and stays for ctl_len cycles.
    always @(posedge CLK_I) begin
        if (RST_I) begin
            m_act       <= 1'b0;
            m_cnt       <= 0;
            i_ctrl_busy <= 1'b0;
        end else if (o_ctrl_stb) begin
            m_act <= 1'b1;
            m_cnt <= 1;
        end else if (m_act) begin
            m_cnt       <= m_cnt + 1;
            i_ctrl_busy <= !ctl_never && (m_cnt >= ctl_delay) && (m_cnt < ctl_delay + ctl_len);
            if (m_cnt >= ctl_delay + ctl_len) m_act <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic append(input logic [8:0] d, input bit exp_wr, input int exp_addr);
        @(negedge CLK_I);
        STB_I = 1'b1; CMT_I = 1'b0; DAT_I = d;
        @(negedge CLK_I);
        STB_I = 1'b0;
        chk("app_ack", ACK_O, 1);
        chk("app_wen", o_wen, exp_wr);
        chk("app_ovf", overflow, !exp_wr);
        if (exp_wr) begin
            chk("app_addr", o_waddr, exp_addr);
            chk("app_data", o_wdata, {23'b0, d});
        end
    endtask

    // Commit with a nonzero count; hold keeps an append request pending while busy.
    task automatic commit(input int exp_addr, input bit hold, input bit exp_err, input int exp_cyc);
        int cyc = 1;
        int stbs = 0;
        int wens = 0;
        int both = 0;
        bit got = 1'b0;
        @(negedge CLK_I);
        STB_I = 1'b1; CMT_I = 1'b1;
        @(negedge CLK_I);
        CMT_I = 1'b0; STB_I = hold; DAT_I = 9'h155;
        chk("stopw_wen", o_wen, 1);
        chk("stopw_addr", o_waddr, exp_addr);
        chk("stopw_data", o_wdata, 16'hC000);
        chk("stopw_busy", busy, 1);
        chk("stopw_ack", ACK_O, 0);
        while (!got && cyc < 200) begin
            @(negedge CLK_I);
            cyc++;
            if (o_ctrl_stb) stbs++;
            if (o_wen) wens++;
            if (o_wen && o_ctrl_stb) both++;
            if (ACK_O) got = 1'b1;
        end
        STB_I = 1'b0;
        chk("cmt_ack", got, 1);
        chk("cmt_stb_cnt", stbs, 1);
        chk("cmt_wen_cnt", wens, 0);
        chk("cmt_wen_stb", both, 0);
        chk("cmt_busy_end", busy, 0);
        chk("cmt_error", error, exp_err);
        if (exp_cyc > 0) chk("cmt_latency", cyc, exp_cyc);
        @(negedge CLK_I);
        chk("cmt_ack_once", ACK_O, 0);
        chk("cmt_no_wr", o_wen, 0);
    endtask

    task automatic commit_empty(input bit exp_prev_err);
        chk("pre_error", error, exp_prev_err);
        @(negedge CLK_I);
        STB_I = 1'b1; CMT_I = 1'b1;
        @(negedge CLK_I);
        STB_I = 1'b0; CMT_I = 1'b0;
        chk("empty_ack", ACK_O, 1);
        chk("empty_wen", o_wen, 0);
        chk("empty_stb", o_ctrl_stb, 0);
        chk("empty_busy", busy, 0);
        chk("empty_err_clr", error, 0);
        @(negedge CLK_I);
        chk("empty_ack_once", ACK_O, 0);
        chk("empty_stb2", o_ctrl_stb, 0);
        chk("empty_busy2", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK_I);
        RST_I = 1'b1; STB_I = 1'b0; CMT_I = 1'b0;
        @(negedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b0;
    endtask

    initial begin
        int wt;
        // Reset state
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b0;
        chk("rst_ack", ACK_O, 0);
        chk("rst_wen", o_wen, 0);
        chk("rst_stb", o_ctrl_stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", error, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_waddr", o_waddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("start_addr", o_start_addr, 0);

        // Two data bytes, then a normal commit with STB_I held during busy
        append(9'h141, 1, 0);
        append(9'h142, 1, 1);
        commit(2, 1, 0, 0);

        // Overflow, including back-to-back acceptance with a held STB_I
        @(negedge CLK_I);
        STB_I = 1'b1; CMT_I = 1'b0; DAT_I = 9'h030;
        @(negedge CLK_I);
        chk("held_ack0", ACK_O, 1);
        chk("held_addr0", o_waddr, 0);
        DAT_I = 9'h031;
        @(negedge CLK_I);
        chk("held_gap_ack", ACK_O, 0);
        chk("held_gap_wen", o_wen, 0);
        @(negedge CLK_I);
        STB_I = 1'b0;
        chk("held_ack1", ACK_O, 1);
        chk("held_addr1", o_waddr, 1);
        chk("held_data1", o_wdata, 16'h0031);
        for (int i = 2; i < 32; i++) append(9'(i), 1, i);
        append(9'h0FF, 0, 0);
        chk("ovf_set", overflow, 1);
        commit(32, 0, 0, 0);
        chk("ovf_clr", overflow, 0);

        // Empty commit
        commit_empty(0);

        // Controller never asserts busy: 16-cycle timeout
        ctl_never = 1'b1;
        append(9'h001, 1, 0);
        commit(1, 0, 1, 20);
        ctl_never = 1'b0;
        commit_empty(1);

        // Controller error reported at busy fall
        i_ctrl_error = 1'b1;
        append(9'h080, 1, 0);
        commit(1, 0, 1, 0);
        i_ctrl_error = 1'b0;

        // Reset pulsed in WAIT_LO abandons the commit
        do_reset();
        append(9'h1AA, 1, 0);
        append(9'h1BB, 1, 1);
        @(negedge CLK_I);
        STB_I = 1'b1; CMT_I = 1'b1;
        @(negedge CLK_I);
        STB_I = 1'b0; CMT_I = 1'b0;
        wt = 0;
        while (!i_ctrl_busy && wt < 50) begin
            @(negedge CLK_I);
            wt++;
        end
        chk("ctl_busy_seen", i_ctrl_busy, 1);
        @(negedge CLK_I);
        chk("wlo_busy", busy, 1);
        RST_I = 1'b1;
        @(negedge CLK_I);
        RST_I = 1'b0;
        chk("rwlo_busy", busy, 0);
        chk("rwlo_ack", ACK_O, 0);
        chk("rwlo_err", error, 0);
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK_I);
            if (ACK_O || busy) chk("rwlo_quiet", {ACK_O, busy}, 0);
        end
        append(9'h0C3, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
